// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU input sequencer: FSM states, button roles and
// the default debounce length.
package alu_seq_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    DISPLAY = 3'd4
  } state_e;

  localparam int unsigned BTN_A  = 0;
  localparam int unsigned BTN_B  = 1;
  localparam int unsigned BTN_OP = 2;

  localparam int unsigned DEB_CYCLES_DEF = 100000;

endpackage

// File: rtl/alu_input_sequencer_debounce.sv
// One push button: 2-flop synchroniser, stability counter, debounced level and
// a one-cycle pulse on each rising edge of the debounced level.
module btn_debounce
  import alu_seq_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_level_q;

  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], i_btn};
      r_level_q <= r_level;
      // The DEB_CYCLES-th consecutive mismatching cycle flips the level.
      if (r_sync[1] != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= ~r_level;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_level & ~r_level_q;

endmodule

// File: rtl/alu_input_sequencer.sv
// Loads operand A, operand B and the opcode from the switches in order, captures
// the ALU result and holds it on the LEDs until the next sequence starts.
module alu_input_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned NB_BTN     = 3,
  parameter int unsigned NB_OP      = 6,
  parameter int unsigned NB_AB      = 4,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic [NB_OP-1:0]   i_sw,
  input  logic [NB_BTN-1:0]  i_btn,
  input  logic [NB_AB-1:0]   i_alu_result,
  output logic [NB_AB-1:0]   o_data_a,
  output logic [NB_AB-1:0]   o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_AB-1:0]   o_led,
  output logic               o_result_valid,
  output logic [STATE_W-1:0] o_state
);

  logic [NB_BTN-1:0] w_press;

  for (genvar gi = 0; gi < NB_BTN; gi++) begin : g_deb
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clock  (clock),
      .i_reset(i_reset),
      .i_btn  (i_btn[gi]),
      .o_press(w_press[gi])
    );
  end

  state_e r_state;
  state_e w_state_d;
  logic   w_load_a;
  logic   w_load_b;
  logic   w_load_op;
  logic   w_capture;

  logic [NB_AB-1:0] r_data_a;
  logic [NB_AB-1:0] r_data_b;
  logic [NB_OP-1:0] r_op;
  logic [NB_AB-1:0] r_led;
  logic             r_valid;

  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_state <= WAIT_A;
    end else begin
      r_state <= w_state_d;
    end
  end

  // btn0 always wins; a lower-priority press in the same cycle is dropped.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      WAIT_A:  if (w_press[BTN_A]) w_state_d = WAIT_B;
      WAIT_B: begin
        if (w_press[BTN_A])      w_state_d = WAIT_B;
        else if (w_press[BTN_B]) w_state_d = WAIT_OP;
      end
      WAIT_OP: begin
        if (w_press[BTN_A])       w_state_d = WAIT_B;
        else if (w_press[BTN_OP]) w_state_d = EXEC;
      end
      EXEC:    w_state_d = DISPLAY;
      DISPLAY: if (w_press[BTN_A]) w_state_d = WAIT_B;
      default: w_state_d = WAIT_A;
    endcase
  end

  always_comb begin
    w_load_a  = 1'b0;
    w_load_b  = 1'b0;
    w_load_op = 1'b0;
    w_capture = 1'b0;
    unique case (r_state)
      WAIT_A, DISPLAY: w_load_a = w_press[BTN_A];
      WAIT_B: begin
        w_load_a = w_press[BTN_A];
        w_load_b = ~w_press[BTN_A] & w_press[BTN_B];
      end
      WAIT_OP: begin
        w_load_a  = w_press[BTN_A];
        w_load_op = ~w_press[BTN_A] & w_press[BTN_OP];
      end
      EXEC:    w_capture = 1'b1;
      default: w_capture = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_data_a <= '0;
      r_data_b <= '0;
      r_op     <= '0;
      r_led    <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_load_a)  r_data_a <= i_sw[NB_AB-1:0];
      if (w_load_b)  r_data_b <= i_sw[NB_AB-1:0];
      if (w_load_op) r_op     <= i_sw;
      if (w_capture) r_led    <= i_alu_result;
      r_valid <= w_capture;
    end
  end

  assign o_data_a       = r_data_a;
  assign o_data_b       = r_data_b;
  assign o_op           = r_op;
  assign o_led          = r_led;
  assign o_result_valid = r_valid;
  assign o_state        = r_state;

endmodule

// File: doc/alu_input_sequencer.md
Name: alu_input_sequencer

Overview:
- Front-end controller for the board-level ALU.
- Debounces the push buttons and edge-detects them.
- Loads operand A, operand B and the opcode from the switches in a strict order.
- Triggers a result capture, then holds the ALU result on the LEDs until the next sequence starts.
- Sits between the board I/O (switches, buttons, LEDs) and the combinational ALU inside the top level.

Parameters:
- NB_BTN, 3, number of buttons (btn0 = load A, btn1 = load B, btn2 = load OP); fixed at 3 for this FSM.
- NB_OP, 6, opcode width and switch-bank width.
- NB_AB, 4, operand and result width (NB_AB <= NB_OP).
- DEB_CYCLES, 100000, cycles a button level must be stable before it is accepted; minimum 1.

Ports:
- clock  in  1  system clock, all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_sw  in  NB_OP  switch bank
- i_btn  in  NB_BTN  raw asynchronous button levels
- i_alu_result  in  NB_AB  combinational ALU result for o_data_a/o_data_b/o_op
- o_data_a  out  NB_AB  registered operand A to ALU
- o_data_b  out  NB_AB  registered operand B to ALU
- o_op  out  NB_OP  registered opcode to ALU
- o_led  out  NB_AB  registered displayed result
- o_result_valid  out  1  one-cycle pulse when o_led updates
- o_state  out  3  current FSM state, for debug LEDs

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous and active-high; it is sampled only on the rising edge of clock.
- Reset values (also applied on reset mid-operation, in any state, including during debounce):
  - o_data_a = 0, o_data_b = 0, o_op = 0, o_led = 0, o_result_valid = 0.
  - State = WAIT_A.
  - Debounce counters = 0; debounced levels = 0.
- Input synchronisation: each i_btn bit passes through a 2-flop synchroniser.
- Debounce:
  - A per-button counter increments while the synchronised level differs from the debounced level.
  - It clears when the levels match.
  - When it reaches DEB_CYCLES, the debounced level flips and the counter clears.
  - A glitch shorter than DEB_CYCLES produces no edge.
- Edge detect: a rising edge of the debounced level gives a one-cycle press pulse p[i].
- Total latency from a clean raw press to p[i] is 2 + DEB_CYCLES + 1 cycles.
- Simultaneous pulses in the same cycle: only the highest-priority pulse valid for the current state is acted on (btn0 > btn1 > btn2); the others are dropped.
- FSM encoding: WAIT_A=0, WAIT_B=1, WAIT_OP=2, EXEC=3, DISPLAY=4.
- FSM transitions:
  - WAIT_A: p[0] -> o_data_a <= i_sw[NB_AB-1:0], go WAIT_B. p[1] and p[2] ignored.
  - WAIT_B:
    - p[0] -> reload A, stay WAIT_B (restart).
    - Else p[1] -> o_data_b <= i_sw[NB_AB-1:0], go WAIT_OP.
    - p[2] ignored.
  - WAIT_OP:
    - p[0] -> reload A, go WAIT_B.
    - Else p[2] -> o_op <= i_sw, go EXEC.
    - p[1] ignored.
  - EXEC (exactly 1 cycle):
    - Operands are stable since the previous edge.
    - o_led <= i_alu_result; o_result_valid = 1 in the following cycle; go DISPLAY.
  - DISPLAY:
    - o_led holds.
    - p[0] -> reload A, go WAIT_B; o_led keeps the old result until the next EXEC.
    - p[1] and p[2] ignored.
- Switch sampling: switches are sampled only in the cycle a press is accepted; switch changes at any other time have no effect.
- Width rules: the upper NB_OP-NB_AB switch bits are discarded for operands. Result truncation is the ALU's responsibility; o_led takes i_alu_result verbatim.
- o_state reflects the registered state every cycle.

Decomposition:
- Shared package alu_seq_pkg:
  - State localparams (WAIT_A..DISPLAY) and state width 3.
  - Button index constants BTN_A=0, BTN_B=1, BTN_OP=2.
  - Default DEB_CYCLES.
- Sub-module btn_debounce (parameter DEB_CYCLES):
  - Contains the synchroniser, counter, debounced level and rising-edge pulse.
  - Instantiated NB_BTN times via generate.
- The top file holds the FSM and output registers.

Test Plan (bench sets DEB_CYCLES=4 and instantiates the team ALU, where op 6'b100000 = ADD and 6'b100100 = AND):
- Normal sequence: sw=6'b000100 + btn0 press (12 cycles) -> o_data_a=4'b0100, o_state=1; sw=6'b001111 + btn1 -> o_data_b=4'b1111, o_state=2; sw=6'b100000 + btn2 -> o_state 3 then 4, o_led=4'b0011, o_result_valid high exactly 1 cycle.
- Glitch rejection: btn1 high for 3 cycles in WAIT_B -> no state change, o_data_b unchanged; held 12 cycles -> accepted.
- Out-of-order and simultaneous presses:
  - In WAIT_A, press btn2 then btn1 -> state stays 0, outputs stay 0.
  - In WAIT_OP, btn0 and btn2 pressed in the same cycle -> A reloaded, state=1, o_op unchanged.
- Restart from DISPLAY: after result 4'b0011, sw=6'b000001 + btn0 -> o_data_a=1, state=1, o_led still 4'b0011 until the next EXEC; then B=4'b0011 and op=6'b100100 -> o_led=4'b0001.
- Reset mid-operation: assert i_reset for 1 cycle in WAIT_OP while btn1 is held -> next cycle all outputs 0, state=0; btn1 still held after reset produces no action once debounced.
